// File: rtl/cmp_pkg.sv
// Shared definitions for the iterative branch comparator: opcode and state
// encodings plus small helpers used by the top level.
package cmp_pkg;

  // Compare opcodes as presented on cmp_op.
  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LT  = 3'd2;
  localparam logic [2:0] CMP_GE  = 3'd3;
  localparam logic [2:0] CMP_LTU = 3'd4;
  localparam logic [2:0] CMP_GEU = 3'd5;

  // Controller states. IDLE and DONE both accept a new request.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of chunks scanned for a given operand width and chunk width.
  function automatic int num_chunks(input int xlen, input int chunk);
    return xlen / chunk;
  endfunction

  // Signed opcodes need the operand sign bits flipped on the MSB chunk so an
  // unsigned magnitude compare orders two's-complement values correctly.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == CMP_LT) || (op == CMP_GE);
  endfunction

  // Map the decided (eq, lt) pair onto the branch-taken bit.
  // Reserved opcodes 6/7 are never taken.
  function automatic logic branch_taken(input logic [2:0] op,
                                        input logic       eq,
                                        input logic       lt);
    logic taken;
    taken = 1'b0;
    case (op)
      CMP_EQ:          taken = eq;
      CMP_NE:          taken = ~eq;
      CMP_LT, CMP_LTU: taken = lt;
      CMP_GE, CMP_GEU: taken = ~lt;
      default:         taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational W-bit slice comparator. With signed_msb set, the top bit of
// both slices is inverted first so the unsigned compare orders signed values.
module cmp_chunk
  import cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         signed_msb,
  output logic         eq,
  output logic         lt
);

  logic [W-1:0] a_m;
  logic [W-1:0] b_m;

  // Optional sign-bit flip followed by an unsigned equal / less-than compare.
  always_comb begin
    a_m = a;
    b_m = b;
    if (signed_msb) begin
      a_m[W-1] = ~a[W-1];
      b_m[W-1] = ~b[W-1];
    end
    eq = (a_m == b_m);
    lt = (a_m < b_m);
  end

endmodule

// File: rtl/cmp_iter.sv
// Multi-cycle branch comparator. Operands are scanned MSB chunk first,
// CHUNK bits per cycle, stopping at the first differing chunk. The result
// bit b is registered on completion and valid pulses for one cycle.
//
// Handshake: a request is accepted on a rising edge where start=1, flush=0
// and ready=1 (state IDLE or DONE); operands and opcode are captured on that
// edge. start while busy is ignored. valid=1 for exactly one cycle (state
// DONE) and b is meaningful in that cycle and held until the next completion.
// flush returns to IDLE on the next edge without producing valid.
module cmp_iter
  import cmp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_d,
  input  logic [XLEN-1:0] rs2_d,
  input  logic [2:0]      cmp_op,
  output logic            ready,
  output logic            busy,
  output logic            valid,
  output logic            b,
  output logic [1:0]      dbg_state
);

  localparam int N  = num_chunks(XLEN, CHUNK);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  // Reject geometries that do not split the operand into whole chunks.
  generate
    if ((CHUNK < 1) || (CHUNK > XLEN) || ((XLEN % CHUNK) != 0)) begin : g_bad_geometry
      $error("cmp_iter: XLEN must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        op_q, op_d;
  logic              res_q, res_d;

  logic [CHUNK-1:0]  slice_a;
  logic [CHUNK-1:0]  slice_b;
  logic              signed_msb;
  logic              c_eq;
  logic              c_lt;
  logic              last_chunk;

  // Select chunk k (k=0 is the most significant chunk) of both operands.
  always_comb begin
    slice_a    = opa_q[(N - 1 - int'(k_q)) * CHUNK +: CHUNK];
    slice_b    = opb_q[(N - 1 - int'(k_q)) * CHUNK +: CHUNK];
    signed_msb = is_signed_op(op_q) && (k_q == '0);
    last_chunk = (k_q == KW'(N - 1));
  end

  cmp_chunk #(
    .W (CHUNK)
  ) u_chunk (
    .a          (slice_a),
    .b          (slice_b),
    .signed_msb (signed_msb),
    .eq         (c_eq),
    .lt         (c_lt)
  );

  // State, chunk index, captured request and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Next-state logic: accept in IDLE/DONE, scan chunk by chunk, flush wins.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    res_d   = res_q;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            opa_d   = rs1_d;
            opb_d   = rs2_d;
            op_d    = cmp_op;
            k_d     = '0;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SCAN: begin
          // A differing chunk decides the compare; equal operands are decided
          // on the last chunk with eq=1, lt=0, which c_eq/c_lt already give.
          if (!c_eq || last_chunk) begin
            res_d   = branch_taken(op_q, c_eq, c_lt);
            state_d = ST_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    busy      = (state_q == ST_SCAN);
    valid     = (state_q == ST_DONE);
    b         = res_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_cmp_iter.sv
// Directed bench for cmp_iter with XLEN=32, CHUNK=8.
module tb_cmp_iter;
  import cmp_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [31:0] rs1_d;
  logic [31:0] rs2_d;
  logic [2:0]  cmp_op;
  logic        ready;
  logic        busy;
  logic        valid;
  logic        b;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_err;

  // Clock and reset-free defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  cmp_iter #(
    .XLEN  (32),
    .CHUNK (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .rs1_d     (rs1_d),
    .rs2_d     (rs2_d),
    .cmp_op    (cmp_op),
    .ready     (ready),
    .busy      (busy),
    .valid     (valid),
    .b         (b),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then count edges after acceptance until valid.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] bb,
                        input logic exp_b, input int exp_edges);
    int edges;
    cmp_op = op;
    rs1_d  = a;
    rs2_d  = bb;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    edges = 0;
    while (!valid && edges < 12) begin
      tick();
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_b"}, 32'(b), 32'(exp_b));
    tick();
    chk({tag, "_pulse_end"}, 32'(valid), 32'd0);
  endtask

  logic [31:0] exp_q[$];

  initial begin
    int nvalid;
    int t;
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    rs1_d  = '0;
    rs2_d  = '0;
    cmp_op = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();

    // Equal operands scan all four chunks.
    run_op("eq_10_10", CMP_EQ, 32'd10, 32'd10, 1'b1, 4);
    run_op("ne_10_10", CMP_NE, 32'd10, 32'd10, 1'b0, 4);
    // Sign difference decided on the MSB chunk.
    run_op("lt_m4_3", CMP_LT, 32'hFFFF_FFFC, 32'd3, 1'b1, 1);
    run_op("ltu_m4_3", CMP_LTU, 32'hFFFF_FFFC, 32'd3, 1'b0, 1);
    // Difference in chunk 2.
    run_op("geu_100_ff", CMP_GEU, 32'h0000_0100, 32'h0000_00FF, 1'b1, 3);
    run_op("ge_m16_m16", CMP_GE, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b1, 4);
    run_op("lt_neg_neg", CMP_LT, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1);

    // Flush in the second SCAN cycle: b keeps 1 although GE 5/6 would give 0.
    cmp_op = CMP_GE;
    rs1_d  = 32'd5;
    rs2_d  = 32'd6;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    flush  = 1'b1;
    tick();
    flush  = 1'b0;
    chk("flush_state", 32'(dbg_state), 32'(ST_IDLE));
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid) nvalid++;
      tick();
    end
    chk("flush_no_valid", 32'(nvalid), 32'd0);
    chk("flush_b_held", 32'(b), 32'd1);

    // start pulsed mid-SCAN is ignored: one result only (EQ 1 vs 2 -> 0).
    cmp_op = CMP_EQ;
    rs1_d  = 32'd1;
    rs2_d  = 32'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    cmp_op = CMP_NE;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    nvalid = 0;
    t = 2;
    exp_q.push_back(32'd4);
    for (int i = 0; i < 10; i++) begin
      if (valid) begin
        nvalid++;
        chk("ign_when", 32'(t), exp_q.pop_front());
        chk("ign_b", 32'(b), 32'd0);
      end
      tick();
      t++;
    end
    chk("ign_count", 32'(nvalid), 32'd1);
    chk("ign_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset asserted mid-SCAN with start high: immediate IDLE, no valid.
    cmp_op = CMP_EQ;
    rs1_d  = 32'd7;
    rs2_d  = 32'd7;
    start  = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_b", 32'(b), 32'd0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid) nvalid++;
    end
    chk("mid_rst_no_valid", 32'(nvalid), 32'd0);

    // Back-to-back: EQ 3/3 then reserved opcode 6 with 3/4, start held.
    cmp_op = CMP_EQ;
    rs1_d  = 32'd3;
    rs2_d  = 32'd3;
    start  = 1'b1;
    tick();
    cmp_op = 3'd6;
    rs2_d  = 32'd4;
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd9);
    nvalid = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 5) start = 1'b0;
      if (valid) begin
        nvalid++;
        if (exp_q.size() != 0) chk("b2b_when", 32'(i), exp_q.pop_front());
        chk("b2b_b", 32'(b), (nvalid == 1) ? 32'd1 : 32'd0);
      end
    end
    chk("b2b_count", 32'(nvalid), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
